// File: rtl/nbit_seq_divider.sv
// Sequential N-bit unsigned restoring divider, one quotient bit per clock.
// Start/Busy/Done handshake; results are held until the next accepted operation.
module nbit_seq_divider #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [N-1:0] Dividend,
  input  logic [N-1:0] Divisor,
  output logic         Busy,
  output logic         Done,
  output logic [N-1:0] Quotient,
  output logic [N-1:0] Remainder,
  output logic         DivByZero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  state_t        next_state;
  logic [N-1:0]  dividend_reg;
  logic [N-1:0]  divisor_reg;
  logic [N-1:0]  part_rem;
  logic [CW-1:0] count;
  logic          accept;
  logic          last_iter;
  logic [N:0]    shifted;
  logic [N:0]    trial;
  logic          q_bit;
  logic [N-1:0]  next_rem;

  // The shifted remainder needs N+1 bits so a divisor with its MSB set cannot
  // overflow the trial subtraction; trial[N] is the borrow (negative) flag.
  always_comb begin
    accept    = Start && ((state == IDLE) || (state == DONE));
    last_iter = (count == CW'(N - 1));
    shifted   = {part_rem, dividend_reg[N-1]};
    trial     = shifted - {1'b0, divisor_reg};
    q_bit     = ~trial[N];
    next_rem  = q_bit ? trial[N-1:0] : shifted[N-1:0];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          next_state = (Divisor == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        Busy = 1'b1;
        if (last_iter) begin
          next_state = DONE;
        end
      end
      DONE: begin
        Done = 1'b1;
        if (Start) begin
          next_state = (Divisor == '0) ? DONE : RUN;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // The dividend register doubles as the quotient shift register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      dividend_reg <= '0;
      divisor_reg  <= '0;
      part_rem     <= '0;
      count        <= '0;
      Quotient     <= '0;
      Remainder    <= '0;
      DivByZero    <= 1'b0;
    end else if (accept) begin
      dividend_reg <= Dividend;
      divisor_reg  <= Divisor;
      part_rem     <= '0;
      count        <= '0;
      if (Divisor == '0) begin
        Quotient  <= '1;
        Remainder <= Dividend;
        DivByZero <= 1'b1;
      end
    end else if (state == RUN) begin
      dividend_reg <= {dividend_reg[N-2:0], q_bit};
      part_rem     <= next_rem;
      count        <= count + CW'(1);
      if (last_iter) begin
        Quotient  <= {dividend_reg[N-2:0], q_bit};
        Remainder <= next_rem;
        DivByZero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nbit_seq_divider.sv
// Self-checking bench for nbit_seq_divider: directed scenarios plus randomized
// operands checked against plain-arithmetic division.
module tb_nbit_seq_divider;

  localparam int N = 8;

  logic         Clk;
  logic         Reset;
  logic         Start;
  logic [N-1:0] Dividend;
  logic [N-1:0] Divisor;
  logic         Busy;
  logic         Done;
  logic [N-1:0] Quotient;
  logic [N-1:0] Remainder;
  logic         DivByZero;

  int checks;
  int failures;

  nbit_seq_divider #(.N(N), .CW(4)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Busy      (Busy),
    .Done      (Done),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .DivByZero (DivByZero)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  function automatic logic [N-1:0] model_q(input logic [N-1:0] a, input logic [N-1:0] b);
    if (b == 0) return {N{1'b1}};
    return N'(int'(a) / int'(b));
  endfunction

  function automatic logic [N-1:0] model_r(input logic [N-1:0] a, input logic [N-1:0] b);
    if (b == 0) return a;
    return N'(int'(a) % int'(b));
  endfunction

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
    Start    = 1'b1;
    Dividend = a;
    Divisor  = b;
    @(negedge Clk);
    Start    = 1'b0;
    Dividend = $urandom_range(0, 255);
    Divisor  = $urandom_range(0, 255);
  endtask

  task automatic wait_done(output int cycles, output int busy_cnt, output bit ok);
    cycles   = 0;
    busy_cnt = 0;
    ok       = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (Done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (Busy === 1'b1) busy_cnt++;
      cycles++;
      @(negedge Clk);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Start = 1'b0;
    Dividend = '0;
    Divisor = '0;
    @(negedge Clk);
    @(negedge Clk);
    checks++;
    if ({Busy, Done, DivByZero} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_flags got=%b want=000", {Busy, Done, DivByZero});
    end
    checks++;
    if ({Quotient, Remainder} !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL reset_results got q=%0d r=%0d want 0/0", Quotient, Remainder);
    end
    Reset = 1'b0;
  endtask

  task automatic test_basic();
    int cyc, bsy;
    bit ok;
    start_op(8'd200, 8'd7);
    wait_done(cyc, bsy, ok);
    checks++;
    if (!ok || cyc != N) begin
      failures++;
      $display("[TB] FAIL basic_latency got=%0d ok=%0d want=%0d", cyc, ok, N);
    end
    checks++;
    if (bsy != N) begin
      failures++;
      $display("[TB] FAIL basic_busy_cycles got=%0d want=%0d", bsy, N);
    end
    checks++;
    if (Quotient !== 8'd28 || Remainder !== 8'd4 || DivByZero !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_result got q=%0d r=%0d z=%b want 28/4/0", Quotient, Remainder, DivByZero);
    end
    @(negedge Clk);
    checks++;
    if (Done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_done_width got=%b want=0", Done);
    end
  endtask

  task automatic test_boundaries();
    logic [N-1:0] as [5] = '{8'd255, 8'd5, 8'd200, 8'd0,  8'd255};
    logic [N-1:0] bs [5] = '{8'd1,   8'd9, 8'd128, 8'd37, 8'd255};
    int cyc, bsy;
    bit ok;
    for (int i = 0; i < 5; i++) begin
      start_op(as[i], bs[i]);
      wait_done(cyc, bsy, ok);
      checks++;
      if (!ok || Quotient !== model_q(as[i], bs[i]) || Remainder !== model_r(as[i], bs[i]) ||
          DivByZero !== 1'b0) begin
        failures++;
        $display("[TB] FAIL boundary_%0d_%0d got q=%0d r=%0d z=%b ok=%0d want q=%0d r=%0d z=0",
                 as[i], bs[i], Quotient, Remainder, DivByZero, ok,
                 model_q(as[i], bs[i]), model_r(as[i], bs[i]));
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_div_by_zero();
    int cyc, bsy;
    bit ok;
    start_op(8'd100, 8'd0);
    wait_done(cyc, bsy, ok);
    checks++;
    if (!ok || cyc != 0 || bsy != 0) begin
      failures++;
      $display("[TB] FAIL divzero_timing got cyc=%0d busy=%0d ok=%0d want 0/0/1", cyc, bsy, ok);
    end
    checks++;
    if (Quotient !== 8'hFF || Remainder !== 8'd100 || DivByZero !== 1'b1) begin
      failures++;
      $display("[TB] FAIL divzero_result got q=%0d r=%0d z=%b want 255/100/1", Quotient, Remainder, DivByZero);
    end
    @(negedge Clk);
    start_op(8'd9, 8'd3);
    checks++;
    if (Busy !== 1'b1 || Quotient !== 8'hFF || DivByZero !== 1'b1) begin
      failures++;
      $display("[TB] FAIL divzero_hold_in_run got busy=%b q=%0d z=%b want 1/255/1", Busy, Quotient, DivByZero);
    end
    wait_done(cyc, bsy, ok);
    checks++;
    if (!ok || Quotient !== 8'd3 || Remainder !== 8'd0 || DivByZero !== 1'b0) begin
      failures++;
      $display("[TB] FAIL after_divzero got q=%0d r=%0d z=%b ok=%0d want 3/0/0", Quotient, Remainder, DivByZero, ok);
    end
    @(negedge Clk);
  endtask

  task automatic test_start_ignored();
    int cyc, bsy;
    bit ok;
    start_op(8'd200, 8'd7);
    @(negedge Clk);
    Start    = 1'b1;
    Dividend = 8'd50;
    Divisor  = 8'd5;
    @(negedge Clk);
    Start = 1'b0;
    wait_done(cyc, bsy, ok);
    checks++;
    if (!ok || cyc != N - 2 || Quotient !== 8'd28 || Remainder !== 8'd4) begin
      failures++;
      $display("[TB] FAIL start_ignored got q=%0d r=%0d cyc=%0d ok=%0d want 28/4 cyc=%0d",
               Quotient, Remainder, cyc, ok, N - 2);
    end
    @(negedge Clk);
  endtask

  task automatic test_back_to_back();
    int cyc, bsy;
    bit ok;
    start_op(8'd200, 8'd7);
    wait_done(cyc, bsy, ok);
    checks++;
    if (!ok || Quotient !== 8'd28 || Remainder !== 8'd4) begin
      failures++;
      $display("[TB] FAIL b2b_first got q=%0d r=%0d ok=%0d want 28/4", Quotient, Remainder, ok);
    end
    start_op(8'd50, 8'd5);
    checks++;
    if (Busy !== 1'b1 || Done !== 1'b0 || Quotient !== 8'd28) begin
      failures++;
      $display("[TB] FAIL b2b_no_dead_cycle got busy=%b done=%b q=%0d want 1/0/28", Busy, Done, Quotient);
    end
    wait_done(cyc, bsy, ok);
    checks++;
    if (!ok || cyc != N || Quotient !== 8'd10 || Remainder !== 8'd0) begin
      failures++;
      $display("[TB] FAIL b2b_second got q=%0d r=%0d cyc=%0d ok=%0d want 10/0 cyc=%0d",
               Quotient, Remainder, cyc, ok, N);
    end
    @(negedge Clk);
  endtask

  task automatic test_reset_mid_run();
    int cyc, bsy, spurious;
    bit ok;
    start_op(8'd200, 8'd7);
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Quotient !== 8'd0 || Remainder !== 8'd0 || DivByZero !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid_run got busy=%b done=%b q=%0d r=%0d z=%b want all 0",
               Busy, Done, Quotient, Remainder, DivByZero);
    end
    spurious = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge Clk);
      if (Done !== 1'b0 || Busy !== 1'b0) spurious++;
    end
    checks++;
    if (spurious != 0) begin
      failures++;
      $display("[TB] FAIL reset_abandons got=%0d active cycles want=0", spurious);
    end
    start_op(8'd9, 8'd3);
    wait_done(cyc, bsy, ok);
    checks++;
    if (!ok || Quotient !== 8'd3 || Remainder !== 8'd0 || DivByZero !== 1'b0) begin
      failures++;
      $display("[TB] FAIL restart_after_reset got q=%0d r=%0d z=%b ok=%0d want 3/0/0", Quotient, Remainder, DivByZero, ok);
    end
    @(negedge Clk);
  endtask

  task automatic test_random();
    logic [N-1:0] a, b;
    int sel, cyc, bsy;
    bit ok;
    for (int i = 0; i < 2000; i++) begin
      a   = N'($urandom_range(0, 255));
      sel = $urandom_range(0, 9);
      if (sel == 0)      b = '0;
      else if (sel == 1) b = 8'd1;
      else if (sel == 2) b = N'($urandom_range(128, 255));
      else               b = N'($urandom_range(0, 255));
      repeat ($urandom_range(0, 2)) @(negedge Clk);
      start_op(a, b);
      wait_done(cyc, bsy, ok);
      checks++;
      if (!ok || cyc != ((b == 0) ? 0 : N) || bsy != cyc) begin
        failures++;
        $display("[TB] FAIL rand_timing %0d/%0d got cyc=%0d busy=%0d ok=%0d want cyc=%0d",
                 a, b, cyc, bsy, ok, (b == 0) ? 0 : N);
      end
      checks++;
      if (Quotient !== model_q(a, b) || Remainder !== model_r(a, b) || DivByZero !== (b == 0)) begin
        failures++;
        $display("[TB] FAIL rand_result %0d/%0d got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b",
                 a, b, Quotient, Remainder, DivByZero, model_q(a, b), model_r(a, b), (b == 0));
      end
      @(negedge Clk);
      checks++;
      if (Done !== 1'b0) begin
        failures++;
        $display("[TB] FAIL rand_done_width %0d/%0d got=%b want=0", a, b, Done);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_boundaries();
    test_div_by_zero();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
